// File: rtl/vga_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_arbiter
// Purpose  : Shares a single-port 80x60 tile memory between VGA scan-out
//            reads, a level-sensitive drawing writer and a screen-clear engine
//            (priority SCAN > CLEAR > WRITE), and produces the registered
//            one-hot pixel colour for vga_interface.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_arbiter #(
    parameter int         TILES_X   = 80,
    parameter int         TILES_Y   = 60,
    parameter logic [7:0] CLR_COLOR = 8'b00000001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    output logic [7:0]  color,
    input  logic        wr_req,
    input  logic [12:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        wr_err,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic [12:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [12:0] C_NTILES  = 13'(TILES_X * TILES_Y);
    localparam logic [12:0] C_LAST    = C_NTILES - 13'd1;
    localparam logic [10:0] C_H_LAST  = 11'd799;
    localparam logic [10:0] C_H_PRE   = 11'd798;
    localparam logic [10:0] C_H_VIS   = 11'd640;
    localparam logic [10:0] C_V_LAST  = 11'd524;
    localparam logic [10:0] C_V_VIS   = 11'd480;
    localparam logic [7:0]  C_BLACK   = 8'b00000001;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [12:0] r_clr_ptr;
    logic [12:0] w_ptr_next;
    logic        r_wr_ack;
    logic        r_wr_err;
    logic        r_slot_d;
    logic [7:0]  r_tile;
    logic [7:0]  r_color;
    logic        w_grant;

    // Scan position two pixels ahead: the fetch must land before the tile is shown
    logic [10:0] w_p;
    logic [10:0] w_line;
    logic        w_slot;
    logic [12:0] w_row;
    logic [12:0] w_slot_addr;
    logic [10:0] w_nh;
    logic [10:0] w_nv;
    logic        w_nvis;
    logic [7:0]  w_tile_next;

    assign w_p    = (hcount >= C_H_PRE) ? (hcount - C_H_PRE) : (hcount + 11'd2);
    assign w_line = (hcount == C_H_PRE) ? ((vcount == C_V_LAST) ? 11'd0 : vcount + 11'd1)
                                        : vcount;
    assign w_slot = (w_p[2:0] == 3'd0) && (w_p < C_H_VIS) && (w_line < C_V_VIS);

    // row*80 + col built from shifts; matches the 80-tile row pitch
    assign w_row       = {2'b00, (w_line >> 3)};
    assign w_slot_addr = (w_row << 6) + (w_row << 4) + {2'b00, (w_p >> 3)};

    // Position of the pixel the colour register will present after this edge
    assign w_nh   = (hcount == C_H_LAST) ? 11'd0 : hcount + 11'd1;
    assign w_nv   = (hcount == C_H_LAST) ? ((vcount == C_V_LAST) ? 11'd0 : vcount + 11'd1)
                                         : vcount;
    assign w_nvis = (w_nh < C_H_VIS) && (w_nv < C_V_VIS);

    // Read data arriving this edge is forwarded so the first pixel of a tile is correct
    assign w_tile_next = r_slot_d ? mem_rdata : r_tile;

    // Port ownership, next state and clear pointer
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_clr_ptr;
        w_grant      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 13'd0;
        mem_wdata    = 8'd0;
        if (w_slot) begin
            mem_addr = w_slot_addr;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // No grant in the ack cycle: the requester may still hold the old request
                    if (wr_req && !r_wr_ack) begin
                        w_grant = 1'b1;
                        if (wr_addr < C_NTILES) begin
                            mem_we    = 1'b1;
                            mem_addr  = wr_addr;
                            mem_wdata = wr_data;
                        end
                    end
                end
                S_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_addr  = r_clr_ptr;
                    mem_wdata = CLR_COLOR;
                    if (r_clr_ptr == C_LAST) begin
                        w_state_next = S_IDLE;
                        w_ptr_next   = 13'd0;
                    end else begin
                        w_ptr_next = r_clr_ptr + 13'd1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
        if (r_state == S_IDLE && clr_start) begin
            w_state_next = S_CLEAR;
            w_ptr_next   = 13'd0;
        end
        if (!reset) begin
            mem_we    = 1'b0;
            mem_addr  = 13'd0;
            mem_wdata = 8'd0;
        end
    end

    // State, pointer, handshake, tile latch and colour registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_clr_ptr <= 13'd0;
            r_wr_ack  <= 1'b0;
            r_wr_err  <= 1'b0;
            r_slot_d  <= 1'b0;
            r_tile    <= C_BLACK;
            r_color   <= C_BLACK;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_ptr_next;
            r_wr_ack  <= w_grant;
            r_wr_err  <= w_grant && (wr_addr >= C_NTILES);
            r_slot_d  <= w_slot;
            r_tile    <= w_tile_next;
            r_color   <= w_nvis ? w_tile_next : C_BLACK;
        end
    end

    assign color    = r_color;
    assign wr_ack   = r_wr_ack;
    assign wr_err   = r_wr_err;
    assign clr_busy = (r_state == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_arbiter
// Purpose  : Scoreboard bench for vga_frame_arbiter with an external tile RAM
//            and a frame-level reference model of fetches, writes and clears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount, vcount;
    logic [7:0]  color;
    logic        wr_req, wr_ack, wr_err, clr_start, clr_busy, mem_we;
    logic [12:0] wr_addr, mem_addr;
    logic [7:0]  wr_data, mem_wdata, mem_rdata;

    vga_frame_arbiter dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .color(color),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .wr_err(wr_err), .clr_start(clr_start), .clr_busy(clr_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #20 clk = ~clk;

    // Tile RAM: synchronous write, one-cycle read latency, preloaded with one-hot a%8
    logic [7:0] tmem [0:8191];
    bit         mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 8192; a++) tmem[a] <= 8'(1 << (a % 8));
            mem_init <= 1'b1;
        end else if (mem_we) begin
            tmem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= tmem[mem_addr];
    end

    typedef struct { int cyc; bit err; } ack_t;
    typedef struct { int addr; int data; } mw_t;
    ack_t aq[$];
    mw_t  mq[$];
    logic [7:0] ref_mem  [0:4799];
    logic [7:0] save_mem [0:4799];

    int checks = 0, errors = 0;
    int cyc = 0, base_cyc = 0, base_fp = 0;
    int bs = 1, be = 0, clr_end = -1, clr_wr_cnt = 0;
    bit chk_color = 1'b0;

    // Frame position (v*800+h) of a given cycle
    function automatic int fp_of(int c);
        return (base_fp + c - base_cyc) % 420000;
    endfunction

    // A fetch happens when the pixel two clocks ahead starts a visible tile
    function automatic bit slot_fp(int fp);
        int q, ph, pv;
        q = (fp + 2) % 420000; ph = q % 800; pv = q / 800;
        return (ph % 8 == 0) && (ph < 640) && (pv < 480);
    endfunction

    function automatic int slot_addr_fp(int fp);
        int q;
        q = (fp + 2) % 420000;
        return ((q / 800) / 8) * 80 + (q % 800) / 8;
    endfunction

    function automatic int first_free(int c);
        int k;
        k = c;
        while (slot_fp(fp_of(k))) k++;
        return k;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (hcount == 11'd799) begin
            hcount = 11'd0;
            vcount = (vcount == 11'd524) ? 11'd0 : vcount + 11'd1;
        end else begin
            hcount = hcount + 11'd1;
        end
    endtask

    task automatic jump(input int vv, input int hh);
        vcount = 11'(vv); hcount = 11'(hh);
        base_cyc = cyc; base_fp = vv * 800 + hh;
    endtask

    task automatic run_until(input int vv, input int hh);
        for (int t = 0; t < 20000; t++) begin
            if (int'(vcount) == vv && int'(hcount) == hh) return;
            step();
        end
        checks++; errors++;
        $display("FAIL run_until_timeout: got v=%0d h=%0d expected v=%0d h=%0d", vcount, hcount, vv, hh);
    endtask

    // Present a request and model when it will be granted; returns in the ack cycle
    task automatic do_write(input int a, input int d, input bit in_ack);
        int from, g; bit ok; ack_t e; mw_t m;
        wr_req = 1'b1; wr_addr = 13'(a); wr_data = 8'(d);
        from = in_ack ? cyc + 1 : cyc;
        if (clr_end >= from) from = clr_end + 1;
        g = first_free(from);
        e.cyc = g + 1; e.err = (a >= 4800); aq.push_back(e);
        if (a < 4800) begin
            m.addr = a; m.data = d; mq.push_back(m); ref_mem[a] = 8'(d);
        end
        ok = 1'b0;
        for (int t = 0; t < 12000; t++) begin
            step();
            if (wr_ack === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wr_ack_timeout: got no ack expected ack for addr %0d", a);
        end
    endtask

    // Clear requested in the current cycle: 4800 writes in the next non-fetch cycles
    task automatic start_clear();
        int k, n; mw_t m;
        k = 0; n = 0;
        while (n < 4800) begin
            k++;
            if (!slot_fp(fp_of(cyc + k))) n++;
        end
        bs = cyc + 1; be = cyc + k; clr_end = be;
        for (int a = 0; a < 4800; a++) begin
            m.addr = a; m.data = 8'h01; mq.push_back(m); ref_mem[a] = 8'h01;
        end
    endtask

    task automatic color_window(input int lines);
        int tv;
        run_until(int'(vcount), 799);
        chk_color = 1'b1;
        tv = (int'(vcount) + lines) % 525;
        run_until(tv, 0);
        chk_color = 1'b0;
    endtask

    // Monitor: scan fetches, memory writes, handshake, busy window and colour
    always @(negedge clk) begin : mon
        int fp; ack_t e; mw_t m; logic [7:0] ec;
        if (reset === 1'b0) begin
            if (mem_we !== 1'b0) begin
                checks++; errors++;
                $display("FAIL mem_we_in_reset: got %b expected 0", mem_we);
            end
        end else begin
            fp = int'(vcount) * 800 + int'(hcount);
            if (slot_fp(fp)) begin
                checks++;
                if (mem_we !== 1'b0 || mem_addr !== 13'(slot_addr_fp(fp))) begin
                    errors++;
                    $display("FAIL scan_slot v=%0d h=%0d: got we=%b addr=%0d expected we=0 addr=%0d",
                             vcount, hcount, mem_we, mem_addr, slot_addr_fp(fp));
                end
            end
            if (mem_we === 1'b1) begin
                checks++;
                if (clr_busy === 1'b1) clr_wr_cnt++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL mem_write: got addr=%0d data=%0h expected no write", mem_addr, mem_wdata);
                end else begin
                    m = mq.pop_front();
                    if (int'(mem_addr) != m.addr || int'(mem_wdata) != m.data) begin
                        errors++;
                        $display("FAIL mem_write: got addr=%0d data=%0h expected addr=%0d data=%0h",
                                 mem_addr, mem_wdata, m.addr, m.data);
                    end
                end
            end
            if (wr_ack === 1'b1) begin
                checks++;
                if (aq.size() == 0) begin
                    errors++;
                    $display("FAIL wr_ack: got ack at cycle %0d expected none", cyc);
                end else begin
                    e = aq.pop_front();
                    if (cyc != e.cyc || wr_err !== e.err) begin
                        errors++;
                        $display("FAIL wr_ack: got cycle=%0d err=%b expected cycle=%0d err=%b",
                                 cyc, wr_err, e.cyc, e.err);
                    end
                end
            end else if (wr_err !== 1'b0) begin
                checks++; errors++;
                $display("FAIL wr_err_alone: got %b expected 0", wr_err);
            end
            checks++;
            if (clr_busy !== ((cyc >= bs) && (cyc <= be))) begin
                errors++;
                $display("FAIL clr_busy cycle %0d: got %b expected %b", cyc, clr_busy, (cyc >= bs) && (cyc <= be));
            end
            if (chk_color) begin
                ec = (hcount < 11'd640 && vcount < 11'd480)
                     ? ref_mem[(int'(vcount) / 8) * 80 + int'(hcount) / 8] : 8'h01;
                checks++;
                if (color !== ec) begin
                    errors++;
                    $display("FAIL color v=%0d h=%0d: got %0h expected %0h", vcount, hcount, color, ec);
                end
            end
        end
    end

    initial begin : main
        int nbad;
        for (int a = 0; a < 4800; a++) ref_mem[a] = 8'(1 << (a % 8));
        reset = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; clr_start = 1'b0;
        jump(7, 600);
        repeat (3) step();
        chk("reset_color", 32'(color), 32'h01);
        chk("reset_wr_ack", 32'(wr_ack), 0);
        chk("reset_wr_err", 32'(wr_err), 0);
        chk("reset_clr_busy", 32'(clr_busy), 0);
        chk("reset_mem_we", 32'(mem_we), 0);
        chk("reset_mem_addr", 32'(mem_addr), 0);
        chk("reset_mem_wdata", 32'(mem_wdata), 0);
        reset = 1'b1;

        // Scan-out of rows 1..2 against the preloaded pattern
        color_window(10);
        // Frame wrap: last invisible line into line 0
        jump(523, 700);
        color_window(2);

        // Directed writes: non-fetch cycle, fetch cycle, out-of-range address
        jump(10, 690);
        run_until(10, 700);
        do_write(5, 8'h10, 1'b0);
        wr_req = 1'b0; step(); step();
        jump(0, 6);
        do_write(100, 8'h04, 1'b0);
        wr_req = 1'b0; step();
        do_write(4800, 8'h80, 1'b0);
        for (int i = 0; i < 150; i++) begin
            int a, d, gap;
            a   = (i % 20 == 0) ? 4800 + int'($urandom_range(0, 300)) : int'($urandom_range(0, 4799));
            d   = 1 << $urandom_range(0, 7);
            gap = int'($urandom_range(0, 3));
            if (gap == 0) begin
                do_write(a, d, 1'b1);
            end else begin
                wr_req = 1'b0;
                repeat (gap) step();
                do_write(a, d, 1'b0);
            end
        end
        wr_req = 1'b0;
        color_window(2);

        // Full clear from the top of the frame, a redundant start, a write held throughout
        jump(0, 0);
        clr_start = 1'b1;
        start_clear();
        step(); clr_start = 1'b0;
        repeat (100) step();
        clr_start = 1'b1; step(); clr_start = 1'b0;
        repeat (50) step();
        do_write(77, 8'h20, 1'b0);
        wr_req = 1'b0;
        color_window(2);

        // Write and clear start together, then reset after 1000 clear writes
        for (int t = 0; t < 10; t++) if (slot_fp(fp_of(cyc)) || wr_ack === 1'b1) step();
        begin
            ack_t e; mw_t m;
            wr_req = 1'b1; wr_addr = 13'd200; wr_data = 8'h40; clr_start = 1'b1;
            e.cyc = first_free(cyc) + 1; e.err = 1'b0; aq.push_back(e);
            m.addr = 200; m.data = 8'h40; mq.push_back(m); ref_mem[200] = 8'h40;
            for (int a = 0; a < 4800; a++) save_mem[a] = ref_mem[a];
            clr_wr_cnt = 0;
            start_clear();
        end
        step(); clr_start = 1'b0; wr_req = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            step();
            if (clr_wr_cnt >= 1000) break;
        end
        chk("clear_writes_before_reset", clr_wr_cnt, 1000);
        reset = 1'b0;
        be = cyc - 1;
        #1;
        chk("midclear_reset_busy", 32'(clr_busy), 0);
        chk("midclear_reset_color", 32'(color), 32'h01);
        chk("midclear_reset_we", 32'(mem_we), 0);
        mq.delete();
        for (int a = 0; a < 4800; a++) ref_mem[a] = (a < 1000) ? 8'h01 : save_mem[a];
        repeat (10) step();
        reset = 1'b1;
        repeat (20) step();

        nbad = 0;
        for (int a = 0; a < 4800; a++) begin
            checks++;
            if (tmem[a] !== ref_mem[a]) begin
                errors++; nbad++;
                if (nbad <= 10) $display("FAIL memory[%0d]: got %0h expected %0h", a, tmem[a], ref_mem[a]);
            end
        end
        chk("write_queue_drained", aq.size(), 0);
        chk("mem_queue_drained", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
